pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/mips_pkg.sv | 13 +
 rtl/hazard_lu_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the hazard FSM state encoding and the hard-wired zero register index.
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_DIV_BUSY  = 2'd1,
    HZ_EXC_DRAIN = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use hazard detector.
// Ports: memtoregE/rtE (execute load), rsD/rtD (decode sources), lu_hit (hazard).
module hazard_lu_detect
  import mips_pkg::*;
(
  input  logic       memtoregE,
  input  logic [4:0] rtE,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  output logic       lu_hit
);

  // A load into the zero register never produces a value to wait for.
  assign lu_hit = memtoregE
                && (rtE != REG_ZERO)
                && ((rtE == rsD) || (rtE == rtD));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: exception flush, divide stall, load-use stall.
// Ports: clk, rst (async active-low), decode/execute hazard inputs,
// stall/flush/div_cancel outputs, perf_stall_cnt/perf_flush_cnt counters.
// Counters are built only when HAZARD_PERF_EN is defined; else tied to 0.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rtE,
  input  logic             memtoregE,
  input  logic             div_startE,
  input  logic             div_doneE,
  input  logic             exceptM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             div_cancel,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  hz_state_t state;
  hz_state_t state_nx;
  logic      lu_hit;

  hazard_lu_detect u_lu (
    .memtoregE (memtoregE),
    .rtE       (rtE),
    .rsD       (rsD),
    .rtD       (rtD),
    .lu_hit    (lu_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HZ_RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    flushW     = 1'b0;
    div_cancel = 1'b0;
    if (!rst) begin
      // Hold the whole pipe empty and the divider aborted while in reset.
      state_nx   = HZ_RUN;
      flushD     = 1'b1;
      flushE     = 1'b1;
      flushM     = 1'b1;
      flushW     = 1'b1;
      div_cancel = 1'b1;
    end else if (exceptM) begin
      state_nx   = HZ_EXC_DRAIN;
      flushD     = 1'b1;
      flushE     = 1'b1;
      flushM     = 1'b1;
      flushW     = 1'b1;
      div_cancel = (state == HZ_DIV_BUSY) || div_startE;
    end else begin
      unique case (state)
        HZ_RUN: begin
          if (div_startE && !div_doneE) begin
            state_nx = HZ_DIV_BUSY;
            stallF   = 1'b1;
            stallD   = 1'b1;
            stallE   = 1'b1;
            flushM   = 1'b1;
          end else if (!div_startE && lu_hit) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end
        HZ_DIV_BUSY: begin
          if (div_doneE) begin
            state_nx = HZ_RUN;
          end else begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
          end
        end
        HZ_EXC_DRAIN: begin
          state_nx = HZ_RUN;
          flushD   = 1'b1;
        end
        default: state_nx = HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF)  stall_cnt <= stall_cnt + CNT_W'(1);
      if (exceptM) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Output vector order: stallF stallD stallE flushD flushE flushM flushW div_cancel.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, rtE;
  logic        memtoregE, div_startE, div_doneE, exceptM;
  logic        stallF, stallD, stallE;
  logic        flushD, flushE, flushM, flushW, div_cancel;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] O_IDLE = 8'b000_0000_0;
  localparam logic [7:0] O_RST  = 8'b000_1111_1;
  localparam logic [7:0] O_EXC  = 8'b000_1111_0;
  localparam logic [7:0] O_EXCC = 8'b000_1111_1;
  localparam logic [7:0] O_DRN  = 8'b000_1000_0;
  localparam logic [7:0] O_DIV  = 8'b111_0010_0;
  localparam logic [7:0] O_LU   = 8'b110_0100_0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rsD            (rsD),
    .rtD            (rtD),
    .rtE            (rtE),
    .memtoregE      (memtoregE),
    .div_startE     (div_startE),
    .div_doneE      (div_doneE),
    .exceptM        (exceptM),
    .stallF         (stallF),
    .stallD         (stallD),
    .stallE         (stallE),
    .flushD         (flushD),
    .flushE         (flushE),
    .flushM         (flushM),
    .flushW         (flushW),
    .div_cancel     (div_cancel),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {stallF, stallD, stallE, flushD, flushE,
            flushM, flushW, div_cancel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    rsD = 5'd1; rtD = 5'd2; rtE = 5'd0;
    memtoregE = 1'b0; div_startE = 1'b0;
    div_doneE = 1'b0; exceptM = 1'b0;
  endtask

  // Inputs change 1ns after posedge; outputs are checked at 5ns (negedge).
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    #4;
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    nxt();
    nxt();
    rst = 1'b1;
  endtask

  logic [31:0] exp_stall;

  initial begin
    rst = 1'b0;
    idle_in();
    #3;
    do_reset();
    chk("rst_scnt", perf_stall_cnt, 32'd0);
    chk("rst_fcnt", perf_flush_cnt, 32'd0);
    nxt();
    #4 chk("run_idle", 32'(outs()), 32'(O_IDLE));

    // Load-use hit on rs, then clear.
    nxt();
    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #4 chk("lu_rs", 32'(outs()), 32'(O_LU));
    nxt();
    idle_in();
    #4 chk("lu_after", 32'(outs()), 32'(O_IDLE));
    // Hit through rt.
    nxt();
    memtoregE = 1'b1; rtE = 5'd9; rtD = 5'd9;
    #4 chk("lu_rt", 32'(outs()), 32'(O_LU));
    // Zero register never stalls.
    nxt();
    memtoregE = 1'b1; rtE = 5'd0; rsD = 5'd0; rtD = 5'd0;
    #4 chk("lu_zero", 32'(outs()), 32'(O_IDLE));
    // Not a load.
    nxt();
    memtoregE = 1'b0; rtE = 5'd7; rsD = 5'd7;
    #4 chk("lu_noload", 32'(outs()), 32'(O_IDLE));
    // Start and done together in RUN: no stall.
    nxt();
    idle_in();
    div_startE = 1'b1; div_doneE = 1'b1;
    #4 chk("div_same", 32'(outs()), 32'(O_IDLE));
    nxt();
    idle_in();
    #4 chk("div_same_nx", 32'(outs()), 32'(O_IDLE));

    // Divide: start at cycle 10, done at cycle 42.
    nxt();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #4 chk("pre_div", 32'(outs()), 32'(O_IDLE));
      nxt();
    end
    div_startE = 1'b1;
    #4 chk("div_c10", 32'(outs()), 32'(O_DIV));
    nxt();
    div_startE = 1'b0;
    for (int c = 11; c < 42; c++) begin
      if (c == 20) memtoregE = 1'b1;
      if (c == 20) rtE = 5'd1;
      #4 chk("div_busy", 32'(outs()), 32'(O_DIV));
      nxt();
      memtoregE = 1'b0; rtE = 5'd0;
    end
    div_doneE = 1'b1;
    #4 chk("div_c42", 32'(outs()), 32'(O_IDLE));
    nxt();
    div_doneE = 1'b0;
    exp_stall = PERF ? 32'd32 : 32'd0;
    #4 chk("div_run", 32'(outs()), 32'(O_IDLE));
    chk("div_scnt", perf_stall_cnt, exp_stall);

    // Exception in the divide start cycle.
    nxt();
    do_reset();
    exceptM = 1'b1; div_startE = 1'b1;
    #4 chk("exc_start", 32'(outs()), 32'(O_EXCC));
    nxt();
    idle_in();
    #4 chk("exc_drain", 32'(outs()), 32'(O_DRN));
    nxt();
    #4 chk("exc_run", 32'(outs()), 32'(O_IDLE));
    nxt();
    memtoregE = 1'b1; rtE = 5'd3; rsD = 5'd3;
    #4 chk("exc_run_lu", 32'(outs()), 32'(O_LU));
    chk("exc_scnt", perf_stall_cnt, 32'd0);
    chk("exc_fcnt", perf_flush_cnt, PERF ? 32'd1 : 32'd0);

    // Exception while divide busy cancels it.
    nxt();
    idle_in();
    div_startE = 1'b1;
    #4 chk("div2_start", 32'(outs()), 32'(O_DIV));
    nxt();
    idle_in();
    exceptM = 1'b1;
    #4 chk("exc_busy", 32'(outs()), 32'(O_EXCC));
    nxt();
    idle_in();
    #4 chk("exc_busy_drn", 32'(outs()), 32'(O_DRN));

    // Back-to-back exceptions.
    nxt();
    do_reset();
    exceptM = 1'b1;
    #4 chk("b2b_1", 32'(outs()), 32'(O_EXC));
    nxt();
    #4 chk("b2b_2", 32'(outs()), 32'(O_EXC));
    nxt();
    exceptM = 1'b0;
    #4 chk("b2b_drn", 32'(outs()), 32'(O_DRN));
    nxt();
    #4 chk("b2b_run", 32'(outs()), 32'(O_IDLE));
    chk("b2b_fcnt", perf_flush_cnt, PERF ? 32'd2 : 32'd0);

    // Reset asserted in the middle of a divide.
    nxt();
    do_reset();
    div_startE = 1'b1;
    nxt();
    div_startE = 1'b0;
    nxt();
    nxt();
    #1 chk("mid_busy", 32'(outs()), 32'(O_DIV));
    #1 rst = 1'b0;
    #1 chk("mid_rst", 32'(outs()), 32'(O_RST));
    chk("mid_scnt", perf_stall_cnt, 32'd0);
    nxt();
    #3 rst = 1'b1;
    nxt();
    #4 chk("mid_run", 32'(outs()), 32'(O_IDLE));
    chk("mid_fcnt", perf_flush_cnt, 32'd0);
    chk("mid_scnt2", perf_stall_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
